// File: rtl/tile_river_fc.sv
// tile_river_fc: one fully-connected layer, out[o] = act(bias[o] + sum_k x[k]*w[o][k]),
// in signed Q(DATA_W-FRAC_W).FRAC_W fixed point. One MAC step per cycle over the
// inputs, with all NUM_OUT accumulators updated in parallel. Weights and biases are
// internal registers loaded through a write port.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_data/in_valid/in_ready   input vector handshake; x[k] at [k*DATA_W +: DATA_W]
//   relu_en              sampled with the input vector; 1 = ReLU on that result
//   out_data/out_valid/out_ready result handshake; out[o] at [o*DATA_W +: DATA_W]
//   out_sat              at least one output of the current result saturated
//   wr_en/wr_addr/wr_data parameter write; addr o*NUM_IN+k = w[o][k], NUM_IN*NUM_OUT+o = bias[o]
//   wr_err               one-cycle pulse when a write was dropped
module tile_river_fc #(
  parameter int NUM_IN  = 10,
  parameter int NUM_OUT = 2,
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_IN*DATA_W-1:0]                      in_data,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic                                          relu_en,
  output logic [NUM_OUT*DATA_W-1:0]                     out_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic                                          out_sat,
  input  logic                                          wr_en,
  input  logic [$clog2(NUM_IN*NUM_OUT+NUM_OUT)-1:0]     wr_addr,
  input  logic [DATA_W-1:0]                             wr_data,
  output logic                                          wr_err
);

  localparam int NPAR  = NUM_IN*NUM_OUT + NUM_OUT;
  localparam int AW    = $clog2(NPAR);
  localparam int KW    = $clog2(NUM_IN);
  localparam int ACC_W = 2*DATA_W + $clog2(NUM_IN) + 1;
  localparam logic [AW:0] NPAR_V = (AW+1)'(NPAR);
  localparam logic signed [ACC_W-1:0] HALF   = ACC_W'(1) << (FRAC_W-1);
  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, ROUND, HOLD} state_t;

  state_t                    state_q, state_d;
  logic [KW-1:0]             k_q;
  logic                      relu_q;
  logic                      sat_q, sat_d;
  logic                      wr_err_q;
  logic signed [DATA_W-1:0]  x_q   [NUM_IN];
  logic signed [DATA_W-1:0]  w_q   [NUM_OUT][NUM_IN];
  logic signed [DATA_W-1:0]  b_q   [NUM_OUT];
  logic signed [ACC_W-1:0]   acc_q [NUM_OUT];
  logic signed [DATA_W-1:0]  y_q   [NUM_OUT];
  logic signed [DATA_W-1:0]  y_d   [NUM_OUT];
  logic signed [2*DATA_W-1:0] prod [NUM_OUT];
  logic signed [ACC_W-1:0]   r_c;
  logic [DATA_W:0]           sv_c;
  logic                      capture, last_k, wr_ok;

  // Round half up: add half an LSB, then arithmetic shift out the fraction.
  function automatic logic signed [ACC_W-1:0] round_half_up(input logic signed [ACC_W-1:0] a);
    return (a + HALF) >>> FRAC_W;
  endfunction

  // Returns {saturated_flag, clamped DATA_W value}.
  function automatic logic [DATA_W:0] saturate(input logic signed [ACC_W-1:0] a);
    if (a > SAT_HI)      return {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
    else if (a < SAT_LO) return {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
    else                 return {1'b0, a[DATA_W-1:0]};
  endfunction

  assign capture = in_valid && in_ready;
  assign last_k  = (k_q == KW'(NUM_IN-1));
  assign wr_ok   = wr_en && (state_q == IDLE || state_q == HOLD) && ({1'b0, wr_addr} < NPAR_V);
  assign out_valid = (state_q == HOLD);
  assign out_sat   = sat_q;
  assign wr_err    = wr_err_q;

  // FSM next state and input-side ready. Reset masks in_ready so a handshake
  // coinciding with rst is never captured.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE:    in_ready = 1'b1;
        HOLD:    in_ready = out_ready;
        default: in_ready = 1'b0;
      endcase
    end
    case (state_q)
      IDLE:    if (capture) state_d = MAC;
      MAC:     if (last_k) state_d = ROUND;
      ROUND:   state_d = HOLD;
      HOLD:    if (out_ready) state_d = capture ? MAC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Stage: MAC products for the current k.
  always_comb begin
    for (int o = 0; o < NUM_OUT; o++) prod[o] = x_q[k_q] * w_q[o][k_q];
  end

  // Stage: round, optional ReLU, saturate.
  always_comb begin
    sat_d = 1'b0;
    r_c   = '0;
    sv_c  = '0;
    for (int o = 0; o < NUM_OUT; o++) begin
      r_c = round_half_up(acc_q[o]);
      if (relu_q && r_c < 0) r_c = '0;
      sv_c   = saturate(r_c);
      y_d[o] = sv_c[DATA_W-1:0];
      sat_d  = sat_d | sv_c[DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q      <= '0;
      wr_err_q <= 1'b0;
      sat_q    <= 1'b0;
      for (int o = 0; o < NUM_OUT; o++) y_q[o] <= '0;
    end else begin
      wr_err_q <= wr_en && !wr_ok;
      if (capture)               k_q <= '0;
      else if (state_q == MAC)   k_q <= k_q + 1'b1;
      if (state_q == ROUND) begin
        sat_q <= sat_d;
        for (int o = 0; o < NUM_OUT; o++) y_q[o] <= y_d[o];
      end
    end
  end

  // Datapath registers carry no reset; the FSM decides when they matter.
  always_ff @(posedge clk) begin
    if (capture) begin
      relu_q <= relu_en;
      for (int k = 0; k < NUM_IN; k++) x_q[k] <= in_data[k*DATA_W +: DATA_W];
      for (int o = 0; o < NUM_OUT; o++) acc_q[o] <= ACC_W'(b_q[o]) <<< FRAC_W;
    end else if (state_q == MAC) begin
      for (int o = 0; o < NUM_OUT; o++) acc_q[o] <= acc_q[o] + ACC_W'(prod[o]);
    end
  end

  // Parameter store; survives reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int o = 0; o < NUM_OUT; o++) begin
        for (int k = 0; k < NUM_IN; k++)
          if (wr_addr == AW'(o*NUM_IN + k)) w_q[o][k] <= wr_data;
        if (wr_addr == AW'(NUM_IN*NUM_OUT + o)) b_q[o] <= wr_data;
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int o = 0; o < NUM_OUT; o++) out_data[o*DATA_W +: DATA_W] = y_q[o];
  end

endmodule

// File: tb/tb_tile_river_fc.sv
module tb_tile_river_fc;
  localparam int NI = 4;
  localparam int NO = 2;
  localparam int DW = 16;
  localparam int FW = 8;
  localparam int AW = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NI*DW-1:0]  in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              relu_en = 1'b0;
  logic [NO*DW-1:0]  out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_sat;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [DW-1:0]     wr_data = '0;
  logic              wr_err;

  int checks = 0;
  int failures = 0;

  tile_river_fc #(.NUM_IN(NI), .NUM_OUT(NO), .DATA_W(DW), .FRAC_W(FW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .relu_en(relu_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sat(out_sat),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pk(input logic [15:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = a[AW-1:0];
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic load(input logic [15:0] w, input logic [15:0] b);
    for (int a = 0; a < NI*NO; a++) wr(a, w);
    for (int a = NI*NO; a < NI*NO+NO; a++) wr(a, b);
  endtask

  // Leaves the caller one #1 after the capture edge.
  task automatic capture(input logic [63:0] x, input logic r);
    int n;
    n = 0;
    in_data  = x;
    relu_en  = r;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin step(); n++; end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL capture_ready: in_ready=%b required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string nm, input logic [15:0] e0, input logic [15:0] e1,
                             input logic es, input int elat);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin step(); n++; end
    if (elat > 0) begin
      checks++;
      if (n !== elat) begin
        failures++;
        $display("FAIL %s_latency: got %0d edges required %0d", nm, n, elat);
      end
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== {e1, e0}) begin
      failures++;
      $display("FAIL %s_data: valid=%b data=%h required %h", nm, out_valid, out_data, {e1, e0});
    end
    checks++;
    if (out_sat !== es) begin
      failures++;
      $display("FAIL %s_sat: got %b required %b", nm, out_sat, es);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_drop: out_valid=%b required 0", nm, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || out_sat !== 1'b0 || wr_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: rdy=%b vld=%b data=%h sat=%b err=%b required 0 0 0 0 0",
               in_ready, out_valid, out_data, out_sat, wr_err);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    load(16'h0100, 16'h0000);
    capture(pk(16'h0100, 16'h0200, 16'h0300, 16'h0400), 1'b0);
    wait_result("basic", 16'h0A00, 16'h0A00, 1'b0, 5);
  endtask

  task automatic test_bias_round();
    for (int a = 0; a < NI; a++) wr(a, 16'h0080);
    wr(8, 16'h0010);
    capture(pk(16'h0001, 16'h0000, 16'h0000, 16'h0000), 1'b0);
    wait_result("bias_round", 16'h0011, 16'h0001, 1'b0, 5);
  endtask

  task automatic test_sat_relu();
    load(16'h7FFF, 16'h0000);
    capture(pk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), 1'b0);
    wait_result("sat_pos", 16'h7FFF, 16'h7FFF, 1'b1, 5);
    load(16'hFF00, 16'h0000);
    capture(pk(16'h0100, 16'h0200, 16'h0300, 16'h0400), 1'b0);
    wait_result("negative", 16'hF600, 16'hF600, 1'b0, 5);
    capture(pk(16'h0100, 16'h0200, 16'h0300, 16'h0400), 1'b1);
    wait_result("relu", 16'h0000, 16'h0000, 1'b0, 5);
  endtask

  task automatic test_back_to_back();
    int n;
    logic bad;
    load(16'h0100, 16'h0000);
    capture(pk(16'h0100, 16'h0200, 16'h0300, 16'h0400), 1'b0);
    n = 0;
    while (!out_valid && n < 40) begin step(); n++; end
    in_data  = pk(16'h0100, 16'h0000, 16'h0000, 16'h0000);
    in_valid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_data !== 32'h0A000A00 || in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_hold: data=%h rdy=%b vld=%b required 0a000a00 0 1",
               out_data, in_ready, out_valid);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_ready: in_ready=%b required 1", in_ready);
    end
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    wait_result("chained", 16'h0100, 16'h0100, 1'b0, 5);
  endtask

  task automatic test_writes();
    capture(pk(16'h0100, 16'h0200, 16'h0300, 16'h0400), 1'b0);
    wr(3, 16'h0200);
    checks++;
    if (wr_err !== 1'b1) begin
      failures++;
      $display("FAIL wr_mac_err: wr_err=%b required 1", wr_err);
    end
    step();
    checks++;
    if (wr_err !== 1'b0) begin
      failures++;
      $display("FAIL wr_mac_pulse: wr_err=%b required 0", wr_err);
    end
    wait_result("wr_mac", 16'h0A00, 16'h0A00, 1'b0, 0);
    wr(10, 16'h1234);
    checks++;
    if (wr_err !== 1'b1) begin
      failures++;
      $display("FAIL wr_range_err: wr_err=%b required 1", wr_err);
    end
    wr(0, 16'h0100);
    checks++;
    if (wr_err !== 1'b0) begin
      failures++;
      $display("FAIL wr_ok_noerr: wr_err=%b required 0", wr_err);
    end
    capture(pk(16'h0100, 16'h0200, 16'h0300, 16'h0400), 1'b0);
    wait_result("wr_after", 16'h0A00, 16'h0A00, 1'b0, 5);
  endtask

  task automatic test_reset_mid();
    capture(pk(16'h0100, 16'h0200, 16'h0300, 16'h0400), 1'b0);
    step(); step();
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_ready: in_ready=%b required 0", in_ready);
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_sat !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_state: vld=%b data=%h sat=%b rdy=%b required 0 0 0 1",
               out_valid, out_data, out_sat, in_ready);
    end
    capture(pk(16'h0100, 16'h0200, 16'h0300, 16'h0400), 1'b0);
    wait_result("rst_rerun", 16'h0A00, 16'h0A00, 1'b0, 5);
    in_data  = pk(16'h0100, 16'h0200, 16'h0300, 16'h0400);
    in_valid = 1'b1;
    rst      = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_wins_capture: in_ready=%b required 1", in_ready);
    end
    repeat (7) step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_wins_novalid: out_valid=%b required 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bias_round();
    test_sat_relu();
    test_back_to_back();
    test_writes();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
